// File: rtl/vend_pkg.sv
// vend_pkg: coin values, coin and dispenser-state encodings shared by the vending blocks
package vend_pkg;
  localparam int DIME_C = 10;
  localparam int QUATER_C = 25;
  localparam int DOLLAR_C = 100;
  typedef enum logic [1:0] {NONE, DIME, QUATER, DOLLAR} coin_t;
  typedef enum logic [2:0] {ST_IDLE, ST_SEL, ST_PULSE, ST_GAP, ST_DONE, ST_ERR} disp_state_t;
  function automatic int coin_val(coin_t c);
    return c == DOLLAR ? DOLLAR_C : c == QUATER ? QUATER_C : c == DIME ? DIME_C : 0;
  endfunction
  function automatic logic [3:0] sat_inc(logic [3:0] n);
    return n == 4'hf ? n : n + 4'd1;
  endfunction
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: change request handshake, coin eject pulses and status
interface change_dispenser_if #(parameter int AMT_W = 10);
  logic ch_valid;
  logic [AMT_W-1:0] ch_amt;
  logic ch_ready;
  logic dollar_out;
  logic quater_out;
  logic dime_out;
  logic [3:0] n_dollar;
  logic [3:0] n_quater;
  logic [3:0] n_dime;
  logic done;
  logic err;
  modport master (
    output ch_valid, ch_amt,
    input ch_ready, dollar_out, quater_out, dime_out, n_dollar, n_quater, n_dime, done, err
  );
  modport slave (
    input ch_valid, ch_amt,
    output ch_ready, dollar_out, quater_out, dime_out, n_dollar, n_quater, n_dime, done, err
  );
endinterface

// File: rtl/pulse_timer.sv
// pulse_timer: loadable down-counter flagging expiry of pulse and gap intervals
module pulse_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         expired
);
  logic [W-1:0] cnt;
  // reload on request, otherwise count down and hold at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= load ? val : cnt != '0 ? cnt - 1'b1 : cnt;
  assign expired = cnt == '0;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays a cents amount out as dollar/quarter/dime eject pulses
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W = 10,
  parameter int PULSE_W = 2,
  parameter int GAP_W = 1
) (
  input logic clk,
  input logic rst,
  change_dispenser_if.slave bus
);
  localparam int TW = 8;
  localparam logic [2:0] IDLE = ST_IDLE;
  localparam logic [2:0] SEL = ST_SEL;
  localparam logic [2:0] PULSE = ST_PULSE;
  localparam logic [2:0] GAP = ST_GAP;
  localparam logic [2:0] DONE = ST_DONE;
  localparam logic [2:0] ERR = ST_ERR;
  logic [2:0] state, state_n;
  logic [AMT_W-1:0] rem;
  coin_t sel, pick;
  logic accept, bad, expired, tload;
  logic [TW-1:0] tval;
  assign accept = state == IDLE && bus.ch_valid;
  // 5 and 15 are multiples of five that cannot be built from 10/25/100
  assign bad = bus.ch_amt % AMT_W'(5) != '0 || bus.ch_amt == AMT_W'(5) || bus.ch_amt == AMT_W'(15);
  // an odd multiple of five needs a quarter first; otherwise largest coin that keeps the rest payable
  assign pick = rem % AMT_W'(10) == AMT_W'(5) ? QUATER :
                rem >= AMT_W'(DOLLAR_C) ? DOLLAR :
                rem >= AMT_W'(50) ? QUATER : DIME;
  assign tload = state == SEL || (state == PULSE && expired);
  assign tval = state == SEL ? TW'(PULSE_W - 1) : TW'(GAP_W - 1);
  pulse_timer #(.W(TW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(tload),
    .val(tval),
    .expired(expired)
  );
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? (bad ? ERR : SEL) : IDLE;
      SEL: state_n = rem == '0 ? DONE : PULSE;
      PULSE: state_n = expired ? GAP : PULSE;
      GAP: state_n = expired ? SEL : GAP;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // remaining amount, selected coin and per-denomination counts
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem <= '0;
      sel <= NONE;
      bus.n_dollar <= '0;
      bus.n_quater <= '0;
      bus.n_dime <= '0;
    end else begin
      if (accept && !bad) begin
        rem <= bus.ch_amt;
        bus.n_dollar <= '0;
        bus.n_quater <= '0;
        bus.n_dime <= '0;
      end
      if (state == SEL) sel <= pick;
      if (state == PULSE && expired) begin
        rem <= rem - AMT_W'(coin_val(sel));
        if (sel == DOLLAR) bus.n_dollar <= sat_inc(bus.n_dollar);
        if (sel == QUATER) bus.n_quater <= sat_inc(bus.n_quater);
        if (sel == DIME) bus.n_dime <= sat_inc(bus.n_dime);
      end
    end
  assign bus.ch_ready = state == IDLE;
  assign bus.done = state == DONE;
  assign bus.err = state == ERR;
  assign bus.dollar_out = state == PULSE && sel == DOLLAR;
  assign bus.quater_out = state == PULSE && sel == QUATER;
  assign bus.dime_out = state == PULSE && sel == DIME;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed request sequence with hand-computed payouts
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  change_dispenser_if #(.AMT_W(10)) b ();
  change_dispenser #(.AMT_W(10), .PULSE_W(2), .GAP_W(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run(input int amt, input bit hold, input int stop_pulse, output int end_cyc,
                     output bit was_err, output int pulses, output int highs, output int first,
                     output int multi);
    logic [2:0] cur, prev;
    int cyc;
    @(negedge clk);
    b.ch_valid = 1'b1;
    b.ch_amt = 10'(amt);
    @(posedge clk);
    #1;
    if (!hold) b.ch_valid = 1'b0;
    b.ch_amt = 10'd1023;
    cyc = 1; end_cyc = 0; was_err = 0; pulses = 0; highs = 0; first = 0; multi = 0; prev = 3'b0;
    while (cyc < 200) begin
      cur = {b.dollar_out, b.quater_out, b.dime_out};
      if ($countones(cur) > 1) multi++;
      if (cur != 3'b0) highs++;
      if (cur != 3'b0 && prev == 3'b0) begin
        pulses++;
        if (pulses == 1) first = int'(cur);
      end
      prev = cur;
      if (stop_pulse != 0 && pulses == stop_pulse) break;
      if (b.done || b.err) begin
        end_cyc = cyc;
        was_err = b.err;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    b.ch_valid = 1'b0;
  endtask
  task automatic req(string tag, int amt, bit hold, int e_cyc, bit e_err, int e_pulses,
                     int e_first, int e_d, int e_q, int e_m);
    int end_cyc, pulses, highs, first, multi;
    bit was_err;
    run(amt, hold, 0, end_cyc, was_err, pulses, highs, first, multi);
    chk({tag, "_cycle"}, end_cyc, e_cyc);
    chk({tag, "_err"}, was_err, e_err);
    chk({tag, "_pulses"}, pulses, e_pulses);
    chk({tag, "_high_cycles"}, highs, 2 * e_pulses);
    chk({tag, "_first_coin"}, first, e_first);
    chk({tag, "_onehot"}, multi, 0);
    chk({tag, "_n_dollar"}, b.n_dollar, e_d);
    chk({tag, "_n_quater"}, b.n_quater, e_q);
    chk({tag, "_n_dime"}, b.n_dime, e_m);
    @(posedge clk);
    #1;
    chk({tag, "_ready_after"}, b.ch_ready, 1);
    chk({tag, "_status_clear"}, {b.done, b.err}, 0);
  endtask
  initial begin
    int end_cyc, pulses, highs, first, multi;
    bit was_err;
    b.ch_valid = 1'b0;
    b.ch_amt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", b.ch_ready, 1);
    chk("rst_outs", {b.dollar_out, b.quater_out, b.dime_out, b.done, b.err}, 0);
    chk("rst_counts", {b.n_dollar, b.n_quater, b.n_dime}, 0);
    @(negedge clk);
    rst = 1'b0;
    req("amt65", 65, 0, 22, 0, 5, 2, 0, 1, 4);
    req("amt230", 230, 0, 22, 0, 5, 4, 2, 0, 3);
    req("amt150", 150, 0, 14, 0, 3, 4, 1, 2, 0);
    req("amt15", 15, 0, 1, 1, 0, 0, 1, 2, 0);
    req("amt37", 37, 0, 1, 1, 0, 0, 1, 2, 0);
    req("amt0", 0, 0, 2, 0, 0, 0, 0, 0, 0);
    req("busy100", 100, 1, 6, 0, 1, 4, 1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_no_second", {b.ch_ready, b.n_dollar}, {1'b1, 4'd1});
    run(230, 0, 2, end_cyc, was_err, pulses, highs, first, multi);
    chk("midrst_reached_pulse2", pulses, 2);
    chk("midrst_dollar_high", b.dollar_out, 1);
    rst = 1'b1;
    #1;
    chk("midrst_outs_low", {b.dollar_out, b.quater_out, b.dime_out}, 0);
    chk("midrst_ready", b.ch_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_idle_after", {b.ch_ready, b.dollar_out, b.quater_out, b.dime_out}, 4'b1000);
    req("after_rst10", 10, 0, 6, 0, 1, 1, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Pays out a change amount as a sequence of physical coin-eject pulses: dollar, quarter and dime, the same three denominations the vending controller accepts. It sits downstream of the vending FSM. When a purchase completes or is cancelled, the FSM hands over the change value in cents, and this block drives the coin hopper solenoids one coin at a time. It reports per-denomination counts for display and signals completion or an undispensable amount.

## Interface
- `AMT_W`, default 10: width of the cents amount (max 1023).
- `PULSE_W`, default 2: cycles each eject pulse is held high (≥1).
- `GAP_W`, default 1: idle cycles after each pulse (≥1).
- `clk` in, 1: system clock.
- `rst` in, 1: asynchronous, active-high reset.
- `ch_valid` in, 1: change request valid.
- `ch_amt` in, AMT_W: change in cents, sampled on accept.
- `ch_ready` out, 1: high only in IDLE; accept = `ch_valid & ch_ready` at a rising edge.
- `dollar_out` out, 1: dollar eject pulse.
- `quater_out` out, 1: quarter eject pulse.
- `dime_out` out, 1: dime eject pulse.
- `n_dollar` out, 4: dollars ejected in the current or last request.
- `n_quater` out, 4: quarters ejected in the current or last request.
- `n_dime` out, 4: dimes ejected in the current or last request.
- `done` out, 1: one-cycle pulse when the request is fully paid.
- `err` out, 1: one-cycle pulse when the request is rejected as undispensable.

## Operation
- States: IDLE, SEL, PULSE, GAP, DONE, ERR.
- **Reset values:** all outputs are 0 except `ch_ready`=1. State is IDLE, `rem`=0.
- **IDLE, on accept:**
  - Invalid amount (`ch_amt % 5 != 0`, or `ch_amt` ∈ {5, 15}): go to ERR. Counts are not cleared.
  - Valid amount: latch `rem = ch_amt`, clear all three counts, go to SEL.
- **SEL (one cycle), selects exactly one action:**
  - `rem == 0`: go to DONE.
  - `rem % 10 == 5`: quarter.
  - Else `rem ≥ 100`: dollar.
  - Else `rem ≥ 50`: quarter.
  - Else: dime.
  - This rule always terminates at exactly 0 for every valid amount; no residue is possible.
- **PULSE:**
  - The selected coin output is high for exactly `PULSE_W` cycles; the other two stay low.
  - On the last PULSE cycle, subtract the coin value (100/25/10) from `rem` and increment the matching count. Counts saturate at 15; `rem` is still decremented.
- **GAP:** all coin outputs low for `GAP_W` cycles, then go to SEL.
- **DONE / ERR:** `done` / `err` high for one cycle, then go to IDLE.
- **Ignored inputs:** `ch_valid` is ignored outside IDLE. `ch_amt` changes after accept have no effect.
- **Coin outputs:** at most one coin output is high in any cycle. Coin outputs are never high outside PULSE.
- **Arithmetic:** `rem` is AMT_W bits and never underflows; selection guarantees `rem ≥` coin value.

## Timing
- Accept at edge E0. SEL occupies cycle 1. The first pulse is high in cycles 2 .. 1+PULSE_W.
- Each coin costs `PULSE_W + GAP_W + 1` cycles, including its trailing SEL.
- For k coins, `done` is high in cycle `2 + k·(PULSE_W+GAP_W+1)`, and `ch_ready` rises the cycle after.
- Zero amount: SEL at cycle 1, `done` at cycle 2, no pulses.
- Error: `err` is high in cycle 1, and `ch_ready` is high again in cycle 2.
- Reset mid-pulse forces all coin outputs low immediately (asynchronously). The request is discarded; there is no resume.
- Counts and status are registered. Coin outputs decode from registered state and coin select only, so they are glitch-free.

## Structure
- Shared package `vend_pkg`:
  - coin value constants `DIME_C`=10, `QUATER_C`=25, `DOLLAR_C`=100;
  - the `coin_t` enum (NONE/DIME/QUATER/DOLLAR);
  - the dispenser state enum.
- Sub-module `pulse_timer`: a loadable down-counter that produces PULSE and GAP expiry. It is instantiated once and reloaded with `PULSE_W-1` or `GAP_W-1`.
- Selection logic and the FSM stay in `change_dispenser`.

## Test plan
All scenarios use the defaults `PULSE_W`=2, `GAP_W`=1.
- **65:** `ch_amt`=65 → quarter, then four dimes. `n_quater`=1, `n_dime`=4. `done` in cycle 22. Exactly 5 two-cycle pulses.
- **230:** `ch_amt`=230 → dollar, dollar, dime ×3. `n_dollar`=2, `n_dime`=3. `done` in cycle 22.
- **150:** `ch_amt`=150 → dollar, quarter, quarter. Counts 1/2/0. `done` in cycle 14.
- **Rejected amounts:** `ch_amt`=15, then 37 → each gives `err` in cycle 1, no coin pulses, prior counts retained.
- **Zero and busy:** `ch_amt`=0 → `done` in cycle 2, counts 0. Then `ch_valid` held high while busy on 100 → only one request is served.
- **Reset mid-pulse:** assert `rst` during the second pulse of a 230 request → outputs drop the same cycle, `ch_ready`=1 after release, a new 10 request gives a single dime.
